// File: rtl/esdi_cmd_scheduler.sv
// esdi_cmd_scheduler: round-robin sharing of the ESDI command serializer between CSR and seek/read requesters.
// Define ESDI_ATTN_POLL_EN to poll drive status automatically on esdi_attention.
module esdi_cmd_scheduler #(
  parameter int          RSP_TIMEOUT     = 2_000_000,
  parameter int          CMD_GAP         = 100,
  parameter logic [16:0] ATTN_STATUS_CMD = 17'h1_0000
) (
  input  logic        csr_aclk,
  input  logic        csr_areset,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [33:0] req_data,
  output logic [1:0]  rsp_valid,
  input  logic [1:0]  rsp_ready,
  output logic [17:0] rsp_data,
  output logic        ser_cmd_valid,
  input  logic        ser_cmd_ready,
  output logic [16:0] ser_cmd_data,
  input  logic        ser_busy,
  input  logic        ser_rsp_valid,
  output logic        ser_rsp_ready,
  input  logic [17:0] ser_rsp_data,
  input  logic        esdi_attention,
  output logic        attn_status_valid,
  output logic [17:0] attn_status_data,
  output logic [1:0]  grant_owner
);
`ifdef ESDI_ATTN_POLL_EN
  localparam bit ATTN_EN = 1'b1;
`else
  localparam bit ATTN_EN = 1'b0;
`endif
  localparam int TMAX = RSP_TIMEOUT > CMD_GAP ? RSP_TIMEOUT : CMD_GAP;
  localparam int TW   = $clog2(TMAX) + 1;
  typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, WAIT_RSP, DELIVER, GAP} state_t;
  state_t      state_q;
  logic [TW-1:0] timer_q, tinc;
  logic        rr_last_q, attn_q, win, take, attn_take;
  logic [16:0] word;
  logic [17:0] rsp_word;
  logic [1:0]  rsp_valid_q, grant_owner_q;
  logic [17:0] rsp_data_q, attn_status_data_q;
  logic [16:0] ser_cmd_data_q;
  logic        ser_cmd_valid_q, ser_rsp_ready_q, attn_status_valid_q;
  // winner is the first valid requester after the last one served
  always_comb begin
    win       = rr_last_q ? ~req_valid[0] : req_valid[1];
    attn_take = ATTN_EN && esdi_attention;
    take      = !csr_areset && state_q == IDLE && !ser_busy;
    req_ready = (take && !attn_take) ? (req_valid & (win ? 2'b10 : 2'b01)) : 2'b00;
    word      = win ? req_data[33:17] : req_data[16:0];
    rsp_word  = ser_rsp_valid ? ser_rsp_data : 18'h2_0000;
    tinc      = timer_q + TW'(timer_q != {TW{1'b1}});
  end
  always_ff @(posedge csr_aclk) begin
    if (csr_areset) begin
      state_q             <= IDLE;
      timer_q             <= '0;
      rr_last_q           <= 1'b1;
      attn_q              <= 1'b0;
      rsp_valid_q         <= 2'b00;
      rsp_data_q          <= '0;
      ser_cmd_valid_q     <= 1'b0;
      ser_cmd_data_q      <= '0;
      ser_rsp_ready_q     <= 1'b0;
      attn_status_valid_q <= 1'b0;
      attn_status_data_q  <= '0;
      grant_owner_q       <= 2'b00;
    end else begin
      ser_rsp_ready_q     <= 1'b1;
      attn_status_valid_q <= 1'b0;
      case (state_q)
        IDLE:
          if (take && attn_take) begin
            ser_cmd_data_q  <= ATTN_STATUS_CMD;
            ser_cmd_valid_q <= 1'b1;
            attn_q          <= 1'b1;
            grant_owner_q   <= 2'b00;
            state_q         <= ISSUE;
          end else if (|req_ready) begin
            ser_cmd_data_q  <= word;
            ser_cmd_valid_q <= 1'b1;
            attn_q          <= 1'b0;
            rr_last_q       <= win;
            grant_owner_q   <= req_ready;
            state_q         <= ISSUE;
          end
        ISSUE:
          if (ser_cmd_ready) begin
            ser_cmd_valid_q <= 1'b0;
            timer_q         <= '0;
            state_q         <= ser_cmd_data_q[16] ? WAIT_RSP : DRAIN;
          end
        DRAIN:
          if (!timer_q[0]) timer_q <= TW'(1);
          else if (!ser_busy) begin
            timer_q       <= '0;
            grant_owner_q <= 2'b00;
            state_q       <= CMD_GAP == 0 ? IDLE : GAP;
          end
        WAIT_RSP:
          if (ser_rsp_valid || timer_q == TW'(RSP_TIMEOUT - 1)) begin
            if (attn_q) begin
              attn_status_valid_q <= 1'b1;
              attn_status_data_q  <= rsp_word;
            end else begin
              rsp_valid_q <= grant_owner_q;
              rsp_data_q  <= rsp_word;
            end
            state_q <= DELIVER;
          end else timer_q <= tinc;
        DELIVER:
          if (attn_q || |(rsp_valid_q & rsp_ready)) begin
            rsp_valid_q   <= 2'b00;
            grant_owner_q <= 2'b00;
            timer_q       <= '0;
            state_q       <= CMD_GAP == 0 ? IDLE : GAP;
          end
        GAP:
          if (timer_q == TW'(CMD_GAP - 1)) state_q <= IDLE;
          else timer_q <= tinc;
        default: state_q <= IDLE;
      endcase
    end
  end
  assign rsp_valid         = rsp_valid_q;
  assign rsp_data          = rsp_data_q;
  assign ser_cmd_valid     = ser_cmd_valid_q;
  assign ser_cmd_data      = ser_cmd_data_q;
  assign ser_rsp_ready     = ser_rsp_ready_q;
  assign attn_status_valid = attn_status_valid_q;
  assign attn_status_data  = attn_status_data_q;
  assign grant_owner       = grant_owner_q;
endmodule

// File: tb/tb_esdi_cmd_scheduler.sv
// tb_esdi_cmd_scheduler: vector table, random traffic against a transaction-level model, corner sequences.
module tb_esdi_cmd_scheduler;
  localparam int RSP_TO = 50;
  localparam int GAP_N  = 100;
  logic clk = 1'b0, rst;
  logic [1:0] req_valid, req_ready, rsp_valid, rsp_ready, grant_owner;
  logic [33:0] req_data;
  logic [17:0] rsp_data, ser_rsp_data, attn_status_data;
  logic [16:0] ser_cmd_data;
  logic ser_cmd_valid, ser_cmd_ready, ser_busy, ser_rsp_valid, ser_rsp_ready;
  logic esdi_attention, attn_status_valid;
  int checks = 0, failures = 0, attn_bad = 0;
  typedef struct {
    logic [1:0] v; logic [33:0] d; int rdy; int rdly; logic [17:0] rsp;
    logic [1:0] g; logic [16:0] cmd; logic [1:0] rv; logic [17:0] rd;
  } vec_t;
  vec_t tbl[8];
  esdi_cmd_scheduler #(.RSP_TIMEOUT(RSP_TO), .CMD_GAP(GAP_N)) dut (
    .csr_aclk(clk), .csr_areset(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .ser_cmd_valid(ser_cmd_valid), .ser_cmd_ready(ser_cmd_ready), .ser_cmd_data(ser_cmd_data),
    .ser_busy(ser_busy), .ser_rsp_valid(ser_rsp_valid), .ser_rsp_ready(ser_rsp_ready),
    .ser_rsp_data(ser_rsp_data), .esdi_attention(esdi_attention),
    .attn_status_valid(attn_status_valid), .attn_status_data(attn_status_data),
    .grant_owner(grant_owner));
  always #5 clk = ~clk;
`ifndef ESDI_ATTN_POLL_EN
  always @(negedge clk) if (attn_status_valid !== 1'b0 || attn_status_data !== 18'h0) attn_bad++;
`endif
  initial begin
    #2ms;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1, "watchdog");
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask
  task automatic expire(input string nm);
    checks++;
    failures++;
    $display("FAIL %s: wait bound expired, required DUT event", nm);
  endtask
  task automatic wait_grant(input string nm);
    int n = 0;
    #1;
    while (req_ready == 2'b00 && n < 400) begin step(); n++; end
    if (req_ready == 2'b00) expire(nm);
  endtask
  // one complete command from request to response acceptance, playing the serializer
  task automatic xact(input logic [1:0] v, input logic [33:0] d, input int rdy, input int rdly,
                      input logic [17:0] rsp, output logic [1:0] g, output logic [16:0] cmd,
                      output logic [1:0] rv, output logic [17:0] rd, output int lat,
                      output int hs, output int bad);
    int n = 0;
    g = 0; cmd = 0; rv = 0; rd = 0; lat = 0; hs = 0; bad = 0;
    req_valid = v; req_data = d;
    #1;
    while (req_ready == 2'b00 && n < 400) begin step(); n++; end
    g = req_ready;
    if (g == 2'b00) begin
      req_valid = 0;
      expire("grant_wait");
      return;
    end
    step();
    req_valid = 0;
    cmd = ser_cmd_data;
    for (int i = 0; i < rdy; i++) begin
      if (ser_cmd_valid !== 1'b1 || ser_cmd_data !== cmd) bad++;
      step();
    end
    ser_cmd_ready = 1;
    if (ser_cmd_valid) hs++;
    step();
    ser_cmd_ready = 0;
    if (ser_cmd_valid) hs++;
    if (cmd[16]) begin
      while (rsp_valid == 2'b00 && lat < RSP_TO + 20) begin
        ser_rsp_valid = (lat == rdly);
        ser_rsp_data = rsp;
        step();
        lat++;
      end
      ser_rsp_valid = 0;
      rv = rsp_valid; rd = rsp_data;
      rsp_ready = rv;
      step();
      rsp_ready = 0;
    end else begin
      ser_busy = 1;
      step(); step();
      ser_busy = 0;
      for (int i = 0; i < 4; i++) begin rv |= rsp_valid; step(); end
    end
  endtask
  initial begin
    logic [1:0] g, rv, eg, erv;
    logic [16:0] cmd, ecmd;
    logic [17:0] rd, erd;
    logic [33:0] d;
    int lat, hs, bad, n, rr_m, w, rdly, seen;
    logic [1:0] v;
    tbl[0] = '{v:2'b11, d:{17'h0_5678, 17'h0_1234}, rdy:3, rdly:-1, rsp:18'h0,      g:2'b01, cmd:17'h0_1234, rv:2'b00, rd:18'h0};
    tbl[1] = '{v:2'b11, d:{17'h0_2222, 17'h0_1111}, rdy:0, rdly:-1, rsp:18'h0,      g:2'b10, cmd:17'h0_2222, rv:2'b00, rd:18'h0};
    tbl[2] = '{v:2'b11, d:{17'h0_3333, 17'h1_0003}, rdy:1, rdly:2,  rsp:18'h0_0BEE, g:2'b01, cmd:17'h1_0003, rv:2'b01, rd:18'h0_0BEE};
    tbl[3] = '{v:2'b11, d:{17'h1_0005, 17'h0_4444}, rdy:0, rdly:0,  rsp:18'h0_00A5, g:2'b10, cmd:17'h1_0005, rv:2'b10, rd:18'h0_00A5};
    tbl[4] = '{v:2'b10, d:{17'h1_0007, 17'h0_0000}, rdy:2, rdly:49, rsp:18'h1_5A5A, g:2'b10, cmd:17'h1_0007, rv:2'b10, rd:18'h1_5A5A};
    tbl[5] = '{v:2'b01, d:{17'h0_0000, 17'h1_0009}, rdy:0, rdly:-1, rsp:18'h0_0111, g:2'b01, cmd:17'h1_0009, rv:2'b01, rd:18'h2_0000};
    tbl[6] = '{v:2'b10, d:{17'h0_ABCD, 17'h0_0000}, rdy:1, rdly:-1, rsp:18'h0,      g:2'b10, cmd:17'h0_ABCD, rv:2'b00, rd:18'h0};
    tbl[7] = '{v:2'b01, d:{17'h0_0000, 17'h0_FFFF}, rdy:4, rdly:-1, rsp:18'h0,      g:2'b01, cmd:17'h0_FFFF, rv:2'b00, rd:18'h0};
    rst = 1; req_valid = 2'b11; req_data = {17'h0_0001, 17'h0_0002}; rsp_ready = 0;
    ser_cmd_ready = 0; ser_busy = 0; ser_rsp_valid = 0; ser_rsp_data = 0; esdi_attention = 0;
    step(); step();
    chk("reset_outputs", {req_ready, rsp_valid, ser_cmd_valid, ser_rsp_ready, attn_status_valid,
        grant_owner, rsp_data, ser_cmd_data, attn_status_data}, 64'h0);
    rst = 0; req_valid = 0;
    step();
    for (int i = 0; i < 8; i++) begin
      xact(tbl[i].v, tbl[i].d, tbl[i].rdy, tbl[i].rdly, tbl[i].rsp, g, cmd, rv, rd, lat, hs, bad);
      chk($sformatf("vec%0d_grant", i), g, tbl[i].g);
      chk($sformatf("vec%0d_cmd", i), cmd, tbl[i].cmd);
      chk($sformatf("vec%0d_handshakes", i), hs, 1);
      chk($sformatf("vec%0d_cmd_stable", i), bad, 0);
      chk($sformatf("vec%0d_rsp_valid", i), rv, tbl[i].rv);
      if (tbl[i].rv != 0) chk($sformatf("vec%0d_rsp_data", i), rd, tbl[i].rd);
      if (tbl[i].cmd[16] && tbl[i].rdly < 0) chk($sformatf("vec%0d_timeout_lat", i), lat, RSP_TO);
    end
    // model: serve first valid requester after the last one; query answered or timed out to owner
    rr_m = 0;
    for (int i = 0; i < 30; i++) begin
      v = 2'($urandom_range(1, 3));
      d = {2'($urandom), $urandom};
      rdly = ($urandom_range(0, 3) == 0) ? -1 : $urandom_range(0, RSP_TO - 1);
      erd = 18'($urandom);
`ifndef ESDI_ATTN_POLL_EN
      esdi_attention = 1'($urandom);
`endif
      w = -1;
      for (int k = 1; k <= 2; k++) if (w < 0 && v[(rr_m + k) % 2]) w = (rr_m + k) % 2;
      rr_m = w;
      eg = (w == 1) ? 2'b10 : 2'b01;
      ecmd = (w == 1) ? d[33:17] : d[16:0];
      erv = ecmd[16] ? eg : 2'b00;
      xact(v, d, $urandom_range(0, 4), rdly, erd, g, cmd, rv, rd, lat, hs, bad);
      if (rdly < 0) erd = 18'h2_0000;
      chk($sformatf("rnd%0d_grant", i), g, eg);
      chk($sformatf("rnd%0d_cmd", i), cmd, ecmd);
      chk($sformatf("rnd%0d_issue", i), {hs, bad}, {32'd1, 32'd0});
      chk($sformatf("rnd%0d_rsp_valid", i), rv, erv);
      if (erv != 0) chk($sformatf("rnd%0d_rsp_data", i), rd, erd);
    end
    esdi_attention = 0;
    xact(2'b01, {17'h0, 17'h1_0011}, 0, -1, 18'h0, g, cmd, rv, rd, lat, hs, bad);
    chk("timeout_lat", lat, RSP_TO);
    chk("timeout_data", {rv, rd}, {2'b01, 18'h2_0000});
    ser_rsp_valid = 1; ser_rsp_data = 18'h0_0077;
    chk("late_rsp_ready", ser_rsp_ready, 1);
    step();
    ser_rsp_valid = 0;
    seen = 0;
    for (int i = 0; i < 30; i++) begin seen |= int'(rsp_valid); step(); end
    chk("late_rsp_discarded", seen, 0);
    req_valid = 2'b01; req_data = {17'h0_0020, 17'h1_0010};
    wait_grant("bp_grant0");
    chk("bp_grant0", req_ready, 2'b01);
    step();
    req_valid = 2'b10;
    ser_cmd_ready = 1; step(); ser_cmd_ready = 0;
    ser_rsp_valid = 1; ser_rsp_data = 18'h0_1357; step(); ser_rsp_valid = 0;
    n = 0;
    while (rsp_valid == 2'b00 && n < 10) begin step(); n++; end
    rsp_ready = 2'b10;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (rsp_valid !== 2'b01 || rsp_data !== 18'h0_1357 || req_ready !== 2'b00 || ser_cmd_valid) bad++;
      step();
    end
    chk("bp_hold", bad, 0);
    rsp_ready = 2'b01; step(); rsp_ready = 0;
    chk("bp_release", rsp_valid, 2'b00);
    wait_grant("bp_grant1");
    chk("bp_grant1", req_ready, 2'b10);
    step();
    req_valid = 0;
    ser_cmd_ready = 1; step(); ser_cmd_ready = 0;
    req_valid = 2'b01; req_data = {17'h0, 17'h0_1234};
    wait_grant("gap_first");
    step();
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      if (ser_cmd_valid !== 1'b1 || ser_cmd_data !== 17'h0_1234) bad++;
      step();
    end
    chk("single_cmd_data", {ser_cmd_valid, ser_cmd_data}, {1'b1, 17'h0_1234});
    ser_cmd_ready = 1; step(); ser_cmd_ready = 0;
    n = 0; seen = 0;
    while (req_ready == 2'b00 && n < 300) begin
      if (ser_cmd_valid) bad++;
      seen |= int'(rsp_valid);
      step();
      n++;
    end
    req_valid = 0;
    chk("single_cmd_once", bad, 0);
    chk("single_cmd_no_rsp", seen, 0);
    chk("gap_len", (n >= GAP_N + 1 && n <= GAP_N + 2), 1);
    for (int i = 0; i < GAP_N + 5; i++) step();
    req_valid = 2'b10; req_data = {17'h1_0033, 17'h0};
    wait_grant("rst_grant");
    step();
    req_valid = 0;
    ser_cmd_ready = 1; step(); ser_cmd_ready = 0;
    for (int i = 0; i < 5; i++) step();
    rst = 1;
    step();
    chk("midop_reset", {req_ready, rsp_valid, ser_cmd_valid, ser_rsp_ready, attn_status_valid,
        grant_owner, rsp_data, ser_cmd_data, attn_status_data}, 64'h0);
    rst = 0;
    ser_rsp_valid = 1; ser_rsp_data = 18'h0_0999; step(); ser_rsp_valid = 0;
    seen = 0;
    for (int i = 0; i < RSP_TO + 10; i++) begin seen |= int'(rsp_valid); step(); end
    chk("aborted_no_rsp", seen, 0);
    xact(2'b11, {17'h0_0B0B, 17'h0_0A0A}, 0, -1, 18'h0, g, cmd, rv, rd, lat, hs, bad);
    chk("post_reset_rr", {g, cmd}, {2'b01, 17'h0_0A0A});
`ifdef ESDI_ATTN_POLL_EN
    esdi_attention = 1; req_valid = 2'b01; req_data = {17'h0, 17'h0_0001};
    n = 0; seen = 0;
    #1;
    while (!ser_cmd_valid && n < 400) begin seen |= int'(req_ready); step(); n++; end
    if (!ser_cmd_valid) expire("attn_issue");
    esdi_attention = 0;
    chk("attn_cmd", {ser_cmd_data, grant_owner}, {17'h1_0000, 2'b00});
    chk("attn_priority", seen, 0);
    ser_cmd_ready = 1; step(); ser_cmd_ready = 0;
    ser_rsp_valid = 1; ser_rsp_data = 18'h0_0042; step(); ser_rsp_valid = 0;
    n = 0;
    while (!attn_status_valid && n < 10) begin step(); n++; end
    chk("attn_status", {attn_status_valid, attn_status_data, rsp_valid}, {1'b1, 18'h0_0042, 2'b00});
    step();
    chk("attn_pulse", attn_status_valid, 0);
    wait_grant("attn_then_req0");
    chk("attn_then_req0", req_ready, 2'b01);
    step();
    req_valid = 0;
    ser_cmd_ready = 1; step(); ser_cmd_ready = 0;
`else
    esdi_attention = 1;
    xact(2'b01, {17'h0, 17'h0_0ABC}, 0, -1, 18'h0, g, cmd, rv, rd, lat, hs, bad);
    chk("attn_ignored", {g, cmd}, {2'b01, 17'h0_0ABC});
    esdi_attention = 0;
    chk("attn_outputs_zero", attn_bad, 0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
